level_sequencer: RTL and testbench

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

---
 rtl/level_sequencer_pkg.sv | 39 +++
 rtl/level_sequencer_frame_event_sync.sv | 48 ++++
 rtl/level_sequencer.sv | 126 ++++++++++++
 tb/tb_level_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_sequencer_pkg.sv
// Shared game definitions: sequencer state encoding, level/frame defaults and screen flags.
// Used by the sequencer as well as the background, enemy and HUD stages.
package level_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRANS = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_t;

  localparam int GAME_MAX_LEVEL    = 3;
  localparam int GAME_TRANS_FRAMES = 120;
  localparam int GAME_END_FRAMES   = 180;
  localparam int LEVEL_W           = 4;
  localparam int FRAME_CNT_W       = 8;

  typedef struct packed {
    logic play_en;
    logic banner_en;
    logic game_over;
    logic game_won;
  } screen_flags_t;

  function automatic screen_flags_t decode_flags(input game_state_t s);
    screen_flags_t f;
    f = '0;
    case (s)
      ST_TRANS: f.banner_en = 1'b1;
      ST_PLAY:  f.play_en   = 1'b1;
      ST_OVER:  f.game_over = 1'b1;
      ST_WIN:   f.game_won  = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/level_sequencer_frame_event_sync.sv
// Vblank rising-edge detector plus sticky event flags, cleared at every frame tick.
// Flags include a pulse arriving in the tick cycle itself, so the sequencer sees it at that tick.
module frame_event_sync (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk_in,
  input  logic start_req,
  input  logic level_clear,
  input  logic player_dead,
  output logic frame_tick,
  output logic start_pend,
  output logic clear_pend,
  output logic dead_pend
);

  logic vblnk_q;
  logic start_q;
  logic clear_q;
  logic dead_q;

  assign frame_tick = vblnk_in & ~vblnk_q;

  assign start_pend = start_q | start_req;
  assign clear_pend = clear_q | level_clear;
  assign dead_pend  = dead_q  | player_dead;

  // Flags drop at every tick, consumed or not, so stale events never carry over a frame.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      if (frame_tick) begin
        start_q <= 1'b0;
        clear_q <= 1'b0;
        dead_q  <= 1'b0;
      end else begin
        start_q <= start_pend;
        clear_q <= clear_pend;
        dead_q  <= dead_pend;
      end
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game flow sequencer: idle, level banner, play, game-over and win screens, advancing only on vblank.
// All outputs are registered and change one pclk after the frame tick.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int MAX_LEVEL    = GAME_MAX_LEVEL,
  parameter int TRANS_FRAMES = GAME_TRANS_FRAMES,
  parameter int END_FRAMES   = GAME_END_FRAMES
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               start_req,
  input  logic               level_clear,
  input  logic               player_dead,
  output logic [LEVEL_W-1:0] level,
  output logic               play_en,
  output logic               banner_en,
  output logic               game_over,
  output logic               game_won
);

  localparam logic [LEVEL_W-1:0]     LVL_FIRST = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0]     LVL_LAST  = LEVEL_W'(MAX_LEVEL);
  localparam logic [FRAME_CNT_W-1:0] CNT_TRANS = FRAME_CNT_W'(TRANS_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_END   = FRAME_CNT_W'(END_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE   = FRAME_CNT_W'(1);

  logic frame_tick;
  logic start_pend;
  logic clear_pend;
  logic dead_pend;

  game_state_t              state;
  game_state_t              nxt_state;
  logic [LEVEL_W-1:0]       nxt_level;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic [FRAME_CNT_W-1:0]   nxt_cnt;
  screen_flags_t            flags;

  frame_event_sync u_sync (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk_in    (vblnk_in),
    .start_req   (start_req),
    .level_clear (level_clear),
    .player_dead (player_dead),
    .frame_tick  (frame_tick),
    .start_pend  (start_pend),
    .clear_pend  (clear_pend),
    .dead_pend   (dead_pend)
  );

  always_comb begin
    nxt_state = state;
    nxt_level = level;
    nxt_cnt   = frame_cnt;
    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          nxt_level = LVL_FIRST;
          if (start_pend) begin
            nxt_state = ST_TRANS;
            nxt_cnt   = CNT_TRANS;
          end
        end
        ST_TRANS: begin
          if (frame_cnt == CNT_ONE) begin
            nxt_state = ST_PLAY;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = frame_cnt - CNT_ONE;
          end
        end
        ST_PLAY: begin
          // Death outranks a simultaneous clear; the level only advances below the last one.
          if (dead_pend) begin
            nxt_state = ST_OVER;
            nxt_cnt   = CNT_END;
          end else if (clear_pend && (level == LVL_LAST)) begin
            nxt_state = ST_WIN;
            nxt_cnt   = CNT_END;
          end else if (clear_pend) begin
            nxt_state = ST_TRANS;
            nxt_level = level + LVL_FIRST;
            nxt_cnt   = CNT_TRANS;
          end
        end
        ST_OVER, ST_WIN: begin
          if (frame_cnt == CNT_ONE) begin
            nxt_state = ST_IDLE;
            nxt_level = LVL_FIRST;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = frame_cnt - CNT_ONE;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_level = LVL_FIRST;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      level     <= LVL_FIRST;
      frame_cnt <= '0;
      flags     <= '0;
    end else begin
      state     <= nxt_state;
      level     <= nxt_level;
      frame_cnt <= nxt_cnt;
      flags     <= decode_flags(nxt_state);
    end
  end

  assign play_en   = flags.play_en;
  assign banner_en = flags.banner_en;
  assign game_over = flags.game_over;
  assign game_won  = flags.game_won;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed game-flow scenarios followed by random event traffic, all compared each cycle with a frame-level model.
module tb_level_sequencer;

  localparam int TF     = 2;
  localparam int EF     = 3;
  localparam int ML     = 3;
  localparam int ACTIVE = 20;
  localparam int VBL    = 5;

  localparam int P_IDLE   = 0;
  localparam int P_BANNER = 1;
  localparam int P_PLAY   = 2;
  localparam int P_OVER   = 3;
  localparam int P_WON    = 4;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk_in = 1'b0;
  logic       start_req = 1'b0;
  logic       level_clear = 1'b0;
  logic       player_dead = 1'b0;
  logic [3:0] level;
  logic       play_en;
  logic       banner_en;
  logic       game_over;
  logic       game_won;

  int n_checks = 0;
  int n_errors = 0;
  int fpos = 0;

  int m_phase;
  int m_level;
  int m_left;
  bit m_vprev;
  bit m_ps;
  bit m_pc;
  bit m_pd;
  bit m_tick;

  level_sequencer #(
    .MAX_LEVEL    (ML),
    .TRANS_FRAMES (TF),
    .END_FRAMES   (EF)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk_in    (vblnk_in),
    .start_req   (start_req),
    .level_clear (level_clear),
    .player_dead (player_dead),
    .level       (level),
    .play_en     (play_en),
    .banner_en   (banner_en),
    .game_over   (game_over),
    .game_won    (game_won)
  );

  initial forever #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_level = 1;
    m_left  = 0;
    m_vprev = 0;
    m_ps    = 0;
    m_pc    = 0;
    m_pd    = 0;
    m_tick  = 0;
  endtask

  // Frame-level rules: the game only moves on at the start of a vblank.
  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    m_tick  = vblnk_in && !m_vprev;
    m_vprev = vblnk_in;
    m_ps = m_ps | start_req;
    m_pc = m_pc | level_clear;
    m_pd = m_pd | player_dead;
    if (!m_tick) return;
    case (m_phase)
      P_IDLE: if (m_ps) begin
        m_phase = P_BANNER;
        m_left  = TF;
      end
      P_BANNER: begin
        m_left--;
        if (m_left == 0) m_phase = P_PLAY;
      end
      P_PLAY: begin
        if (m_pd) begin
          m_phase = P_OVER;
          m_left  = EF;
        end else if (m_pc && m_level == ML) begin
          m_phase = P_WON;
          m_left  = EF;
        end else if (m_pc) begin
          m_level++;
          m_phase = P_BANNER;
          m_left  = TF;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = P_IDLE;
          m_level = 1;
        end
      end
    endcase
    m_ps = 0;
    m_pc = 0;
    m_pd = 0;
  endtask

  task automatic compare_all();
    chk("level",     level,     m_level);
    chk("play_en",   play_en,   m_phase == P_PLAY);
    chk("banner_en", banner_en, m_phase == P_BANNER);
    chk("game_over", game_over, m_phase == P_OVER);
    chk("game_won",  game_won,  m_phase == P_WON);
  endtask

  // One pclk: frame timing driven at the negedge, model advanced at the posedge, outputs sampled at the next negedge.
  task automatic cyc();
    vblnk_in = (fpos >= ACTIVE);
    @(posedge pclk);
    model_step();
    fpos = (fpos + 1) % (ACTIVE + VBL);
    @(negedge pclk);
    compare_all();
    start_req   = 1'b0;
    level_clear = 1'b0;
    player_dead = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_tick(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * (ACTIVE + VBL) && !seen; i++) begin
      cyc();
      seen = m_tick;
    end
    chk({tag, "_tick_seen"}, seen, 1);
  endtask

  task automatic align_to_tick();
    for (int i = 0; i < ACTIVE + VBL && fpos != ACTIVE; i++) cyc();
  endtask

  task automatic start_and_play(input string tag);
    run_cycles(3);
    start_req = 1'b1;
    cyc();
    run_to_tick({tag, "_s"});
    run_to_tick({tag, "_t1"});
    run_to_tick({tag, "_t2"});
    chk({tag, "_play"}, play_en, 1);
  endtask

  task automatic clear_and_play(input string tag);
    run_cycles(4);
    level_clear = 1'b1;
    cyc();
    run_to_tick({tag, "_c"});
    run_to_tick({tag, "_t1"});
    run_to_tick({tag, "_t2"});
    chk({tag, "_play"}, play_en, 1);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    run_cycles(3);
    chk("rst_level",  level,     1);
    chk("rst_play",   play_en,   0);
    chk("rst_banner", banner_en, 0);
    chk("rst_over",   game_over, 0);
    chk("rst_won",    game_won,  0);
    rst = 1'b1;
    run_cycles(2);

    // Start from IDLE: banner for two ticks, then play at level 1.
    run_cycles(4);
    start_req = 1'b1;
    cyc();
    run_to_tick("start");
    chk("start_banner", banner_en, 1);
    chk("start_noplay", play_en, 0);
    run_to_tick("start_t1");
    chk("start_banner2", banner_en, 1);
    run_to_tick("start_t2");
    chk("start_play", play_en, 1);
    chk("start_level", level, 1);

    // Mid-frame clear: level is frozen until the next tick.
    run_cycles(8);
    level_clear = 1'b1;
    cyc();
    for (int i = 0; i < 2 * (ACTIVE + VBL); i++) begin
      cyc();
      if (m_tick) break;
      chk("prog_level_hold", level, 1);
    end
    chk("prog_level", level, 2);
    chk("prog_banner", banner_en, 1);
    run_to_tick("prog_t1");
    run_to_tick("prog_t2");
    chk("prog_play2", play_en, 1);

    clear_and_play("lvl3");
    chk("lvl3_level", level, 3);

    // Clear on the last level wins; the win screen lasts END_FRAMES ticks.
    run_cycles(5);
    level_clear = 1'b1;
    cyc();
    run_to_tick("win");
    chk("win_flag1", game_won, 1);
    chk("win_level", level, 3);
    run_to_tick("win_t1");
    chk("win_flag2", game_won, 1);
    run_to_tick("win_t2");
    chk("win_flag3", game_won, 1);
    run_to_tick("win_t3");
    chk("win_idle_won", game_won, 0);
    chk("win_idle_level", level, 1);
    chk("win_idle_play", play_en, 0);
    chk("win_idle_banner", banner_en, 0);

    // A start pulse during the banner must not restart it.
    run_cycles(3);
    start_req = 1'b1;
    cyc();
    run_to_tick("dstart");
    run_cycles(3);
    start_req = 1'b1;
    cyc();
    run_to_tick("dstart_t1");
    chk("dstart_banner", banner_en, 1);
    run_to_tick("dstart_t2");
    chk("dstart_play", play_en, 1);
    chk("dstart_level", level, 1);
    clear_and_play("dstart_l2");
    chk("dstart_l2_level", level, 2);

    // Death and clear together in the tick cycle: death wins, level held.
    align_to_tick();
    player_dead = 1'b1;
    level_clear = 1'b1;
    cyc();
    chk("prio_over", game_over, 1);
    chk("prio_level", level, 2);
    chk("prio_won", game_won, 0);

    // Clear during game-over is dropped and leaves no trace in IDLE.
    run_cycles(4);
    level_clear = 1'b1;
    cyc();
    run_to_tick("dclr_t1");
    chk("dclr_over", game_over, 1);
    chk("dclr_level", level, 2);
    run_to_tick("dclr_t2");
    run_to_tick("dclr_t3");
    chk("dclr_idle_level", level, 1);
    chk("dclr_idle_over", game_over, 0);
    run_to_tick("dclr_t4");
    run_to_tick("dclr_t5");
    chk("dclr_stay_banner", banner_en, 0);
    chk("dclr_stay_play", play_en, 0);

    // Asynchronous reset mid-play at level 2, checked before the next edge.
    start_and_play("rstp");
    clear_and_play("rstp_l2");
    chk("rstp_level2", level, 2);
    run_cycles(3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", level, 1);
    chk("arst_play", play_en, 0);
    chk("arst_banner", banner_en, 0);
    model_reset();
    @(negedge pclk);
    run_cycles(2);
    rst = 1'b1;
    run_cycles(2);

    for (int i = 0; i < 2000; i++) begin
      start_req   = ($urandom_range(0, 39) == 0);
      level_clear = ($urandom_range(0, 49) == 0);
      player_dead = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
